// File: rtl/instr_fetch.sv
// Instruction fetch responder: one word read per PC request, buffered until the datapath consumes it.
// Optional bus timeout fault is compiled in with `define IFETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] next_pc,
  input  logic        next_pc_en,
  input  logic        dp_ready,
  output logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [1:0]  inst_fault_cause,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t      state_r, state_s;
  logic        mem_ren_r, mem_ren_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_pc_r, inst_pc_s;
  logic        inst_valid_r, inst_valid_s;
  logic        inst_fault_r, inst_fault_s;
  logic [1:0]  cause_r, cause_s;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] cnt_r, cnt_s;
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = TIMEOUT_CYCLES;
`endif

  // Next-state and next-output computation; every register holds unless a transition updates it.
  always_comb begin
    state_s      = state_r;
    mem_ren_s    = mem_ren_r;
    mem_addr_s   = mem_addr_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
    inst_fault_s = inst_fault_r;
    cause_s      = cause_r;
`ifdef IFETCH_TIMEOUT_EN
    cnt_s        = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (next_pc_en) begin
          if (next_pc[1:0] != 2'b00) begin
            inst_s       = NOP_INST;
            inst_pc_s    = next_pc;
            inst_fault_s = 1'b1;
            cause_s      = CAUSE_MISALGN;
            inst_valid_s = 1'b1;
            state_s      = HOLD;
          end else begin
            mem_addr_s = next_pc;
            mem_ren_s  = 1'b1;
            state_s    = REQ;
`ifdef IFETCH_TIMEOUT_EN
            cnt_s      = 16'd0;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // An ack always wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          inst_s       = mem_rdata;
          inst_pc_s    = mem_addr_r;
          inst_fault_s = 1'b0;
          cause_s      = CAUSE_NONE;
          inst_valid_s = 1'b1;
          mem_ren_s    = 1'b0;
          state_s      = HOLD;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (cnt_r == TIMEOUT_LAST) begin
          inst_s       = NOP_INST;
          inst_pc_s    = mem_addr_r;
          inst_fault_s = 1'b1;
          cause_s      = CAUSE_TIMEOUT;
          inst_valid_s = 1'b1;
          mem_ren_s    = 1'b0;
          state_s      = HOLD;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
`else
        else begin
          state_s = REQ;
        end
`endif
      end
      HOLD: begin
        if (dp_ready) begin
          inst_valid_s = 1'b0;
          state_s      = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s      = IDLE;
        mem_ren_s    = 1'b0;
        inst_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= IDLE;
      mem_ren_r    <= 1'b0;
      mem_addr_r   <= 32'd0;
      inst_r       <= NOP_INST;
      inst_pc_r    <= 32'd0;
      inst_valid_r <= 1'b0;
      inst_fault_r <= 1'b0;
      cause_r      <= CAUSE_NONE;
    end else begin
      state_r      <= state_s;
      mem_ren_r    <= mem_ren_s;
      mem_addr_r   <= mem_addr_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
      inst_fault_r <= inst_fault_s;
      cause_r      <= cause_s;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  // Wait counter for the current memory request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

  assign inst_ready       = inst_valid_r & dp_ready;
  assign inst_valid       = inst_valid_r;
  assign inst             = inst_r;
  assign inst_pc          = inst_pc_r;
  assign inst_fault       = inst_fault_r;
  assign inst_fault_cause = cause_r;
  assign mem_ren          = mem_ren_r;
  assign mem_addr         = mem_addr_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed steps plus randomized fetches against a
// transaction-level model (memory array, expected entry per fetch); honours IFETCH_TIMEOUT_EN.
module tb_instr_fetch;

  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] next_pc;
  logic        next_pc_en;
  logic        dp_ready;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [1:0]  inst_fault_cause;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_arr [64];
  logic [31:0] last_inst;
  logic [31:0] last_pc;

  instr_fetch #(.TIMEOUT_CYCLES(TO), .NOP_INST(NOP)) dut (
    .clk(clk), .nrst(nrst), .next_pc(next_pc), .next_pc_en(next_pc_en),
    .dp_ready(dp_ready), .inst_ready(inst_ready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_fault_cause(inst_fault_cause), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive point just after the rising edge; check point on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Runs a fetch whose request at pc was sampled on the edge just before this call.
  task automatic finish_fetch(input logic [31:0] pc, input int lat, input int w);
    logic [31:0] e_inst;
    logic        e_fault;
    logic [1:0]  e_cause;
    bit          timed_out;
    int          n;
    cyc();
    next_pc_en = 1'b0;
    next_pc    = $urandom;
    mem_ack    = 1'b0;
    dp_ready   = (w == 0);
    if (pc[1:0] != 2'b00) begin
      e_inst = NOP; e_fault = 1'b1; e_cause = 2'b01;
    end else begin
      timed_out = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      timed_out = (lat >= TO);
`endif
      n = timed_out ? TO : lat + 1;
      dp_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (k > 0) cyc();
        mem_ack   = (!timed_out && k == lat);
        mem_rdata = mem_ack ? mem_arr[pc[7:2]] : $urandom;
        mid();
        chk("req_ren", 32'(mem_ren), 32'd1);
        chk("req_addr", mem_addr, pc);
        chk("req_valid", 32'(inst_valid), 32'd0);
      end
      cyc();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      dp_ready  = (w == 0);
      if (timed_out) begin
        e_inst = NOP; e_fault = 1'b1; e_cause = 2'b10;
      end else begin
        e_inst = mem_arr[pc[7:2]]; e_fault = 1'b0; e_cause = 2'b00;
      end
    end
    for (int h = 0; h <= w; h++) begin
      if (h > 0) begin
        cyc();
        dp_ready  = (h == w);
        mem_ack   = (h != w) ? ((h == 2) | 1'($urandom_range(0, 1))) : 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      mid();
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_ready", 32'(inst_ready), 32'(h == w));
      chk("hold_ren", 32'(mem_ren), 32'd0);
      chk("hold_inst", inst, e_inst);
      chk("hold_pc", inst_pc, pc);
      chk("hold_fault", 32'(inst_fault), 32'(e_fault));
      chk("hold_cause", 32'(inst_fault_cause), 32'(e_cause));
    end
    // first idle cycle: spurious ack must not disturb the retained entry
    cyc();
    dp_ready   = 1'($urandom_range(0, 1));
    mem_ack    = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    next_pc_en = 1'b0;
    mid();
    chk("idle_valid", 32'(inst_valid), 32'd0);
    chk("idle_ready", 32'(inst_ready), 32'd0);
    chk("idle_ren", 32'(mem_ren), 32'd0);
    chk("idle_inst", inst, e_inst);
    chk("idle_pc", inst_pc, pc);
    last_inst = e_inst;
    last_pc   = pc;
  endtask

  task automatic fetch(input logic [31:0] pc, input int lat, input int w);
    cyc();
    next_pc    = pc;
    next_pc_en = 1'b1;
    mem_ack    = 1'b0;
    dp_ready   = 1'b0;
    mid();
    chk("pres_ren", 32'(mem_ren), 32'd0);
    chk("pres_valid", 32'(inst_valid), 32'd0);
    chk("pres_inst", inst, last_inst);
    chk("pres_pc", inst_pc, last_pc);
    finish_fetch(pc, lat, w);
  endtask

  initial begin
    logic [31:0] pc;
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h0050_0093;
    last_inst  = NOP;
    last_pc    = 32'd0;

    nrst       = 1'b0;
    next_pc    = 32'd0;
    next_pc_en = 1'b1;
    dp_ready   = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) mid();
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ready", 32'(inst_ready), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    chk("rst_cause", 32'(inst_fault_cause), 32'd0);

    cyc();
    nrst     = 1'b1;
    dp_ready = 1'b0;
    finish_fetch(32'd0, 3, 0);
    fetch(32'd4, 0, 0);
    fetch(32'd8, 1, 5);
    fetch(32'h0000_0102, 0, 1);
`ifdef IFETCH_TIMEOUT_EN
    fetch(32'd12, 20, 4);
    fetch(32'd16, TO - 1, 0);
`else
    fetch(32'd12, 20, 2);
`endif

    for (int t = 0; t < 40; t++) begin
      pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      fetch(pc, $urandom_range(0, 12), $urandom_range(0, 3));
    end

    // asynchronous reset while a request is outstanding
    cyc();
    next_pc    = 32'h0000_0020;
    next_pc_en = 1'b1;
    mem_ack    = 1'b0;
    cyc();
    next_pc_en = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_ren", 32'(mem_ren), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, NOP);
    cyc();
    nrst      = 1'b1;
    last_inst = NOP;
    last_pc   = 32'd0;
    fetch(32'h0000_0024, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch responder that sits between the program counter and instruction memory.
- Accepts the PC's fetch request (next_pc / next_pc_en) and performs a single-word read on a simple req/ack memory port.
- Buffers the returned instruction and presents it to the datapath.
- Pulses inst_ready for exactly one cycle when the datapath consumes the instruction; that pulse is what advances the PC.
- Misaligned fetches, and bus timeouts when the optional feature is compiled in, are reported as fault entries instead of instructions.

Parameters:
TIMEOUT_CYCLES, 255, number of mem_ren cycles without mem_ack before a timeout fault is raised (used only with IFETCH_TIMEOUT_EN; legal range 1..65535).
NOP_INST, 32'h0000_0013, instruction value loaded at reset and on fault entries (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
next_pc  in  32  fetch address from the PC
next_pc_en  in  1  fetch request valid
dp_ready  in  1  datapath able to consume the buffered instruction this cycle
inst_ready  out  1  instruction consumed this cycle; one-cycle pulse that advances the PC
inst_valid  out  1  buffered instruction/fault entry is valid
inst  out  32  buffered instruction
inst_pc  out  32  address of the buffered instruction
inst_fault  out  1  buffered entry is a fault
inst_fault_cause  out  2  00 none, 01 misaligned, 10 bus timeout, 11 reserved
mem_ren  out  1  memory read request
mem_addr  out  32  memory read address, word aligned
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory response strobe

Behaviour:
- Reset is asynchronous and active-low: nrst low immediately forces:
  - state=IDLE
  - mem_ren=0, mem_addr=0
  - inst=NOP_INST, inst_pc=0
  - inst_valid=0, inst_fault=0, inst_fault_cause=00
  - timeout counter=0
- Reset mid-transaction abandons the request; the memory side must tolerate mem_ren dropping.
- All outputs are registered, except inst_ready = inst_valid & dp_ready, which is combinational.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - next_pc_en=0: stay in IDLE.
  - next_pc[1:0]!=00: no memory access; load inst=NOP_INST, inst_pc=next_pc, inst_fault=1, cause=01; go to HOLD.
  - next_pc aligned: register mem_addr=next_pc and mem_ren=1; go to REQ. mem_ren is visible the cycle after the request is sampled.
- REQ:
  - mem_ren and mem_addr are held stable until mem_ack.
  - On mem_ack: capture inst=mem_rdata, inst_pc=mem_addr, inst_fault=0, cause=00; mem_ren=0 next cycle; go to HOLD.
  - Zero-wait ack (mem_ack in the first REQ cycle) is legal.
- HOLD:
  - inst_valid=1; inst, inst_pc and fault fields are stable.
  - When dp_ready=1: inst_ready pulses for that cycle; go to IDLE with inst_valid=0. inst and inst_pc keep their values.
  - When dp_ready=0: hold indefinitely; no new memory request is issued.
- A new fetch starts only from IDLE, after consumption. next_pc therefore already reflects any branch redirect, and no flush path exists.
- mem_ack while mem_ren=0 (IDLE/HOLD) is ignored; state, inst and inst_pc are unchanged.
- next_pc_en is sampled only in IDLE.
- Minimum throughput: one instruction per 3 cycles (IDLE, REQ with immediate ack, HOLD with dp_ready=1).
- inst_fault_cause=11 is never produced.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to REQ and increments every REQ cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES without ack: next cycle mem_ren=0, inst=NOP_INST, inst_pc=mem_addr, inst_fault=1, cause=10; go to HOLD.
  - mem_ack in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal capture, no fault.
  - A late ack after timeout is ignored.
- Undefined: no counter; REQ waits for mem_ack forever; cause 10 is never produced.

Test Plan:
- Reset: hold nrst=0 → mem_ren=0, inst_valid=0, inst_ready=0, inst=32'h00000013, cause=00. Release with next_pc=0, next_pc_en=1 → mem_ren=1, mem_addr=0 on the following cycle.
- Normal fetch: mem_ack after 3 wait cycles with mem_rdata=32'h00500093, dp_ready=1 → next cycle inst_valid=1, inst=32'h00500093, inst_pc=0, single inst_ready pulse, then a new request at mem_addr=4.
- Backpressure: dp_ready=0 for 5 cycles in HOLD → inst stable, inst_ready=0, mem_ren=0. dp_ready=1 → exactly one inst_ready pulse.
- Misaligned: next_pc=32'h00000102 → no mem_ren; next cycle inst_valid=1, inst_fault=1, cause=01, inst_pc=32'h00000102, inst=NOP.
- Spurious ack: pulse mem_ack with mem_rdata=32'hDEADBEEF in IDLE and in HOLD → no state or inst change.
- Timeout (IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8): never ack → after 8 REQ cycles mem_ren drops, inst_fault=1, cause=10, inst_pc=mem_addr; a late ack 2 cycles later is ignored. Ack in the 8th cycle instead → normal capture, cause=00.
